// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Width helpers let forwarding-select and latency fields track the tracked depth.
package hazard_pkg;

  localparam int LAT_ALU   = 1;
  localparam int LAT_LOAD  = 2;
  localparam int TAG_RD_W  = 5;
  localparam int TAG_LAT_W = 2;

  // Layout of one in-flight destination tag for the default configuration
  typedef struct packed {
    logic                 valid;
    logic [TAG_RD_W-1:0]  rd;
    logic [TAG_LAT_W-1:0] lat;
  } tag_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority search over the in-flight tags.
// The youngest matching stage decides between forwarding and a hazard.
module hazard_match import hazard_pkg::*; #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2,
  localparam int SEL_W         = sel_width(DEPTH),
  localparam int LAT_W         = sel_width(DEPTH)
) (
  input  logic [DEPTH-1:0]                tag_valid,
  input  logic [DEPTH*REG_ADDR_WIDTH-1:0] tag_rd,
  input  logic [DEPTH*LAT_W-1:0]          tag_lat,
  input  logic [REG_ADDR_WIDTH-1:0]       rs_addr,
  input  logic                            rs_used,
  output logic [SEL_W-1:0]                sel,
  output logic                            hazard
);

  logic found_s;

  // Stage 1 is searched first so the youngest producer wins
  always_comb begin
    sel     = '0;
    hazard  = 1'b0;
    found_s = 1'b0;
    if (rs_used && (rs_addr != '0)) begin
      for (int s = 1; s <= DEPTH; s++) begin
        if (!found_s && tag_valid[s-1] &&
            (tag_rd[(s-1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs_addr)) begin
          found_s = 1'b1;
          if (int'(tag_lat[(s-1)*LAT_W +: LAT_W]) <= s) begin
            sel = SEL_W'(s);
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end else begin
      sel    = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: tracks destination tags through DEPTH post-issue stages,
// drives per-operand forward selects and the load-use/latency stall.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 2,
  parameter int STALL_CNT_W    = 16,
  localparam int SEL_W         = sel_width(DEPTH),
  localparam int LAT_W         = sel_width(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic                              id_we,
  input  logic [REG_ADDR_WIDTH-1:0]         id_rd,
  input  logic [LAT_W-1:0]                  id_lat,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [NUM_SRC-1:0]                rs_used,
  input  logic                              flush,
  input  logic                              ext_hold,
  input  logic                              cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]          src_sel,
  output logic                              stall,
  output logic [STALL_CNT_W-1:0]            stall_cnt
);

  logic [DEPTH-1:0]                tag_valid_r;
  logic [DEPTH*REG_ADDR_WIDTH-1:0] tag_rd_r;
  logic [DEPTH*LAT_W-1:0]          tag_lat_r;
  logic [NUM_SRC-1:0]              hazard_s;
  logic [STALL_CNT_W-1:0]          stall_cnt_r;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    hazard_match #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .DEPTH         (DEPTH)
    ) u_match (
      .tag_valid(tag_valid_r),
      .tag_rd   (tag_rd_r),
      .tag_lat  (tag_lat_r),
      .rs_addr  (rs_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .rs_used  (rs_used[i]),
      .sel      (src_sel[i*SEL_W +: SEL_W]),
      .hazard   (hazard_s[i])
    );
  end

  // A flushed instruction never stalls; it is being discarded anyway
  assign stall     = id_valid & (|hazard_s) & ~flush;
  assign stall_cnt = stall_cnt_r;

  // Tag shift register; a flush drops the old stage-1 entry instead of shifting it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_r <= '0;
      tag_rd_r    <= '0;
      tag_lat_r   <= '0;
    end else if (ext_hold) begin
      if (flush) begin
        tag_valid_r[0] <= 1'b0;
      end
    end else begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        tag_valid_r[s] <= (s == 1 && flush) ? 1'b0 : tag_valid_r[s-1];
        tag_rd_r[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] <= tag_rd_r[(s-1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        tag_lat_r[s*LAT_W +: LAT_W] <= tag_lat_r[(s-1)*LAT_W +: LAT_W];
      end
      if (id_valid && !flush && !stall) begin
        tag_valid_r[0]                <= id_we && (id_rd != '0);
        tag_rd_r[0 +: REG_ADDR_WIDTH] <= id_rd;
        tag_lat_r[0 +: LAT_W]         <= id_lat;
      end else begin
        tag_valid_r[0] <= 1'b0;
      end
    end
  end

  // Saturating hazard-stall cycle counter; a held pipeline does not count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (cnt_clr) begin
      stall_cnt_r <= '0;
    end else if (stall && !ext_hold && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard, checked against a queue-based
// model of the in-flight instruction window.
module tb_hazard_scoreboard;

  localparam int W  = 5;
  localparam int NS = 2;
  localparam int D  = 2;
  localparam int CW = 16;
  localparam int SW = 2;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_we, flush, ext_hold, cnt_clr;
  logic [W-1:0]    id_rd;
  logic [LW-1:0]   id_lat;
  logic [NS*W-1:0] rs_addr;
  logic [NS-1:0]   rs_used;
  logic [NS*SW-1:0] src_sel;
  logic            stall;
  logic [CW-1:0]   stall_cnt;

  hazard_scoreboard #(
    .REG_ADDR_WIDTH(W), .NUM_SRC(NS), .DEPTH(D), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
    .id_lat(id_lat), .rs_addr(rs_addr), .rs_used(rs_used), .flush(flush),
    .ext_hold(ext_hold), .cnt_clr(cnt_clr), .src_sel(src_sel), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    int lat;
  } ent_t;

  ent_t pipe[$];
  int   mcnt;
  int   exp_sel[NS];
  bit   exp_stall;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sel_of(input int i);
    return int'(src_sel[i*SW +: SW]);
  endfunction

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.rd = 0; e.lat = 0;
    pipe.delete();
    for (int s = 0; s < D; s++) pipe.push_back(e);
    mcnt = 0;
  endtask

  // Youngest matching in-flight instruction decides: forward if its result is ready there
  task automatic model_eval();
    bit any;
    int a;
    any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      exp_sel[i] = 0;
      a = int'(rs_addr[i*W +: W]);
      if (rs_used[i] && a != 0) begin
        for (int s = 0; s < D; s++) begin
          if (pipe[s].v && pipe[s].rd == a) begin
            if (s + 1 >= pipe[s].lat) exp_sel[i] = s + 1;
            else any = 1'b1;
            break;
          end
        end
      end
    end
    exp_stall = id_valid && any && !flush;
  endtask

  task automatic model_step();
    ent_t e;
    if (ext_hold) begin
      if (flush) pipe[0].v = 1'b0;
    end else begin
      if (flush) pipe[0].v = 1'b0;
      e.v   = id_valid && !flush && !exp_stall && id_we && (id_rd != 0);
      e.rd  = int'(id_rd);
      e.lat = int'(id_lat);
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    if (cnt_clr) mcnt = 0;
    else if (exp_stall && !ext_hold && mcnt != 65535) mcnt++;
  endtask

  task automatic cycle(input string tag);
    #2;
    model_eval();
    for (int i = 0; i < NS; i++)
      check($sformatf("%s/sel%0d", tag, i), 32'(sel_of(i)), 32'(exp_sel[i]));
    check({tag, "/stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "/cnt"}, 32'(stall_cnt), 32'(mcnt));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_we = 1'b0; id_rd = '0; id_lat = 2'd1;
    rs_addr = '0; rs_used = '0; flush = 1'b0; ext_hold = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic issue(input int rd, input int lat);
    id_valid = 1'b1; id_we = 1'b1; id_rd = W'(rd); id_lat = LW'(lat);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with sources pointing at x5/x6
    rs_addr = {5'd6, 5'd5}; rs_used = 2'b11;
    #1;
    check("rst/sel0", 32'(sel_of(0)), 32'd0);
    check("rst/sel1", 32'(sel_of(1)), 32'd0);
    check("rst/stall", 32'(stall), 32'd0);
    check("rst/cnt", 32'(stall_cnt), 32'd0);
    cycle("rst");

    // ALU result forwarded from stage 1, then stage 2, then regfile
    issue(5, 1); cycle("alu_issue");
    id_valid = 1'b0; id_we = 1'b0; rs_addr = {5'd0, 5'd5}; rs_used = 2'b01;
    #1; check("alu/s1", 32'(sel_of(0)), 32'd1); check("alu/s1_stall", 32'(stall), 32'd0);
    cycle("alu1");
    #1; check("alu/s2", 32'(sel_of(0)), 32'd2);
    cycle("alu2");
    #1; check("alu/rf", 32'(sel_of(0)), 32'd0);
    cycle("alu3");

    // Load-use: exactly one stall cycle, then forward from stage 2
    idle(); issue(7, 2); cycle("ld_issue");
    idle(); id_valid = 1'b1; rs_addr = {5'd7, 5'd0}; rs_used = 2'b10;
    #1; check("ld/stall", 32'(stall), 32'd1);
    cycle("ld_stall");
    #1; check("ld/fwd", 32'(sel_of(1)), 32'd2); check("ld/nostall", 32'(stall), 32'd0);
    check("ld/cnt", 32'(stall_cnt), 32'd1);
    cycle("ld_fwd");

    // Back-to-back x3 writers: youngest wins; x0 never forwards
    idle(); issue(3, 1); cycle("x3a");
    issue(3, 1); cycle("x3b");
    issue(0, 1); rs_addr = {5'd0, 5'd3}; rs_used = 2'b11;
    #1; check("x3/young", 32'(sel_of(0)), 32'd1); check("x3/x0", 32'(sel_of(1)), 32'd0);
    cycle("x3c");
    idle(); rs_addr = {5'd0, 5'd0}; rs_used = 2'b11;
    #1; check("x0/sel0", 32'(sel_of(0)), 32'd0); check("x0/sel1", 32'(sel_of(1)), 32'd0);
    cycle("x0");

    // Flush kills both the consumer and the stage-1 load
    idle(); issue(9, 2); cycle("fl_issue");
    issue(10, 1); rs_addr = {5'd0, 5'd9}; rs_used = 2'b01; flush = 1'b1;
    #1; check("fl/stall", 32'(stall), 32'd0);
    cycle("fl");
    flush = 1'b0; id_we = 1'b0;
    #1; check("fl/gone", 32'(sel_of(0)), 32'd0); check("fl/nostall", 32'(stall), 32'd0);
    cycle("fl_after");

    // ext_hold freezes tags and the counter while a hazard is pending
    idle(); issue(4, 2); cycle("hold_issue");
    idle(); id_valid = 1'b1; rs_addr = {5'd0, 5'd4}; rs_used = 2'b01; ext_hold = 1'b1;
    c0 = mcnt;
    for (int k = 0; k < 3; k++) begin
      #1; check("hold/stall", 32'(stall), 32'd1); check("hold/cnt", 32'(stall_cnt), 32'(c0));
      cycle("hold");
    end
    ext_hold = 1'b0;
    #1; check("hold/rel_stall", 32'(stall), 32'd1);
    cycle("hold_rel");
    #1; check("hold/fwd", 32'(sel_of(0)), 32'd2); check("hold/cnt1", 32'(stall_cnt), 32'(c0 + 1));
    cycle("hold_fwd");

    // Saturation at all-ones, then synchronous clear
    idle(); issue(8, 2); cycle("sat_issue");
    force dut.stall_cnt_r = 16'hFFFF;
    #1;
    release dut.stall_cnt_r;
    mcnt = 65535;
    idle(); id_valid = 1'b1; rs_addr = {5'd0, 5'd8}; rs_used = 2'b01;
    #1; check("sat/stall", 32'(stall), 32'd1);
    cycle("sat");
    cnt_clr = 1'b1;
    #1; check("sat/hold", 32'(stall_cnt), 32'hFFFF);
    cycle("clr");
    cnt_clr = 1'b0;
    #1; check("clr/zero", 32'(stall_cnt), 32'd0);
    cycle("clr_after");

    // Randomized traffic against the window model
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_we    = ($urandom_range(0, 4) != 0);
      id_rd    = W'($urandom_range(0, 7));
      id_lat   = LW'($urandom_range(1, 2));
      rs_addr  = {W'($urandom_range(0, 7)), W'($urandom_range(0, 7))};
      rs_used  = NS'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 9) == 0);
      ext_hold = ($urandom_range(0, 7) == 0);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the two-port forwarding selector.
- Keeps its own shift register of in-flight destination tags across DEPTH post-issue stages.
- Supports NUM_SRC operand ports and per-instruction result latency (ALU, load, multi-cycle).
- Produces per-operand forward selects and a load-use/latency stall. Sits in decode, driving the EX operand muxes and the IF/ID hold.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- NUM_SRC, 2, number of source operand ports checked per cycle.
- DEPTH, 2, number of forwarding stages tracked (stage 1 = EX/MEM latch … stage DEPTH = last stage before regfile write).
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- Derived (localparam): SEL_W = $clog2(DEPTH+1); LAT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction issuing this cycle
- id_we  in  1  issuing instruction writes a register
- id_rd  in  REG_ADDR_WIDTH  issuing destination
- id_lat  in  LAT_W  first stage (1..DEPTH) at which the result is forwardable
- rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  packed source addresses, port i at [i*W +: W]
- rs_used  in  NUM_SRC  per-port "operand actually read"
- flush  in  1  kill issuing instruction and stage-1 entry (branch resolved in EX)
- ext_hold  in  1  freeze whole pipeline (memory wait)
- cnt_clr  in  1  synchronous clear of stall counter
- src_sel  out  NUM_SRC*SEL_W  per-port forward select: 0 = regfile, s = stage s
- stall  out  1  hold IF/ID, insert bubble into stage 1
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Tag entry per stage: {valid, rd, lat}. An entry with id_we=0 or id_rd=0 is stored with valid=0.
- Combinational lookup for port i, with rs_addr[i] != 0 and rs_used[i]=1:
  - Search stages 1..DEPTH. The lowest-numbered (youngest) valid entry with rd == rs_addr[i] wins.
  - Match at stage s with s >= lat: src_sel[i] = s, hazard_i = 0.
  - Match at stage s with s < lat: src_sel[i] = 0, hazard_i = 1.
  - No match, rs_addr[i]=0, or rs_used[i]=0: src_sel[i] = 0, hazard_i = 0.
- stall = id_valid & |hazard & ~flush. This path is purely combinational, with no added latency.
- Entries leaving stage DEPTH are considered written to the regfile. The regfile is write-first, so no stage DEPTH+1 exists.
- Register update (posedge clk, or rst):
  - rst: all entries valid=0, stall_cnt=0. Outputs then read src_sel=0, stall=0.
  - ext_hold=1: no stage advances. If flush=1, stage 1 valid is cleared. Issue is blocked.
  - ext_hold=0, stall=1: stages 2..DEPTH <= stages 1..DEPTH-1; stage 1 <= bubble.
  - ext_hold=0, stall=0: stages shift. Stage 1 <= issuing tag if id_valid & ~flush, else bubble. On flush, the old stage-1 entry is discarded (not shifted into stage 2).
- Stall counter:
  - Increments when stall & ~ext_hold.
  - Saturates at all-ones.
  - cnt_clr takes priority over increment.
- Compatibility: with DEPTH=2 and all lat=1, src_sel encoding equals the predecessor (1 = MEM, 2 = WB).
- Simultaneous: stall and ext_hold both high → hold wins (no bubble inserted, counter not incremented).
- Reset mid-operation drops all tags. The pipeline owner must flush the datapath alongside.

Decomposition:
- Package hazard_pkg:
  - tag_t struct {valid, rd, lat}.
  - LAT_ALU=1, LAT_LOAD=2 constants.
  - Helper function sel_width(depth).
- Sub-module hazard_match: one instance per source port. Pure combinational priority search over the tag vector, returning {sel, hazard}.

Test Plan:
- Reset, then rs_addr={x5,x6}, no tags → src_sel={0,0}, stall=0, stall_cnt=0.
- Issue ALU rd=x5 (lat=1); next cycle rs1=x5 → src_sel[0]=1, stall=0; one cycle later → src_sel[0]=2; then 0.
- Issue load rd=x7 (lat=2); next cycle rs2=x7 → stall=1 for exactly one cycle, stall_cnt=1; following cycle src_sel[1]=2, stall=0.
- Back-to-back writes to x3 (lat 1), with x3 at stages 1 and 2, and rs1=x3 → src_sel[0]=1 (youngest wins). rs=x0 with a tag rd=x0 issued → src_sel=0.
- Load rd=x9 in stage 1, rs1=x9, flush=1 same cycle → stall=0. Next cycle, stage 1 is a bubble and x9 is not in stage 2.
- ext_hold=1 for 3 cycles during a pending hazard → tags frozen, stall_cnt unchanged. Separately: force the counter to 0xFFFF and hold stall → stays 0xFFFF; cnt_clr → 0.
